// File: rtl/sseg_pkg.sv
// Shared types, constants and the leading-zero mask helper for the
// seven-segment scan controller.
package sseg_pkg;

  localparam int MAX_DIGITS = 16;

  localparam logic [6:0] SSEG_BLANK = 7'h7F;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  // Bit i set when nibbles i..n_digits-1 are all zero; digit 0 is never masked.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [4*MAX_DIGITS-1:0] value,
    input int                      n_digits
  );
    logic                  zero_above;
    logic [MAX_DIGITS-1:0] m;
    zero_above = 1'b1;
    m          = '0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (i < n_digits) begin
        zero_above = zero_above & (value[4*i +: 4] == 4'h0);
        m[i]       = zero_above & (i != 0);
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/sseg_scan_ctrl_hex2sseg.sv
// Hex nibble to active-low gfedcba segment pattern decoder.
module hex2sseg
  import sseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  nibble_t hex_s;
  seg_t    seg_s;

  assign hex_s = hex;
  assign seg   = seg_s;

  // Segment lookup, lower-case b and d keep them distinct from 8 and 0.
  always_comb begin
    seg_s = SSEG_BLANK;
    case (hex_s)
      4'h0:    seg_s = 7'b1000000;
      4'h1:    seg_s = 7'b1111001;
      4'h2:    seg_s = 7'b0100100;
      4'h3:    seg_s = 7'b0110000;
      4'h4:    seg_s = 7'b0011001;
      4'h5:    seg_s = 7'b0010010;
      4'h6:    seg_s = 7'b0000010;
      4'h7:    seg_s = 7'b1111000;
      4'h8:    seg_s = 7'b0000000;
      4'h9:    seg_s = 7'b0010000;
      4'hA:    seg_s = 7'b0001000;
      4'hB:    seg_s = 7'b0000011;
      4'hC:    seg_s = 7'b1000110;
      4'hD:    seg_s = 7'b0100001;
      4'hE:    seg_s = 7'b0000110;
      4'hF:    seg_s = 7'b0001110;
      default: seg_s = SSEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with double-buffered
// frames, leading-zero blanking and per-slot PWM dimming.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1_000,
  parameter int N_DIGITS   = 8,
  parameter int DUTY_BITS  = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   en_mask,
  input  logic                  lz_blank,
  input  logic [DUTY_BITS-1:0]  duty,
  output logic                  load_ack,
  output logic                  frame_start,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            sseg,
  output logic                  dp
);

  localparam int DIV       = CLK_HZ / REFRESH_HZ;
  localparam int PHASES    = 1 << DUTY_BITS;
  localparam int PHASE_LEN = DIV / PHASES;
  localparam int CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SUB_W     = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam int IDX_W     = $clog2(N_DIGITS);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DIV - 1);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(PHASE_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]           tick_cnt_r;
  logic [SUB_W-1:0]           sub_cnt_r;
  logic [DUTY_BITS-1:0]       phase_r;
  logic [IDX_W-1:0]           idx_r;
  logic [N_DIGITS-1:0][3:0]   active_r;
  logic [N_DIGITS-1:0][3:0]   pending_r;
  logic [N_DIGITS-1:0]        active_dp_r;
  logic [N_DIGITS-1:0]        pending_dp_r;
  logic                       pend_flag_r;
  logic                       wrap_r;

  logic [N_DIGITS-1:0]        an_r;
  seg_t                       sseg_r;
  logic                       dp_r;
  logic                       load_ack_r;
  logic                       frame_start_r;

  logic                       tick_s;
  logic                       wrap_s;
  logic                       xfer_s;
  nibble_t                    nibble_s;
  logic [6:0]                 dec_seg_s;
  logic [4*MAX_DIGITS-1:0]    val_ext_s;
  logic [MAX_DIGITS-1:0]      lz_full_s;
  logic [3:0]                 idx_ext_s;
  logic                       blank_s;
  logic [N_DIGITS-1:0]        an_next_s;
  seg_t                       sseg_next_s;
  logic                       dp_next_s;

  assign tick_s   = (tick_cnt_r == TICK_LAST);
  assign wrap_s   = tick_s & (idx_r == IDX_LAST);
  assign xfer_s   = wrap_s & pend_flag_r;
  assign nibble_s = active_r[idx_r];

  assign load_ack    = load_ack_r;
  assign frame_start = frame_start_r;
  assign an          = an_r;
  assign sseg        = sseg_r;
  assign dp          = dp_r;

  // Slot prescaler, dimming phase and digit index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_r <= '0;
      sub_cnt_r  <= '0;
      phase_r    <= '0;
      idx_r      <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
      sub_cnt_r  <= '0;
      phase_r    <= '0;
      if (idx_r == IDX_LAST) begin
        idx_r <= '0;
      end else begin
        idx_r <= idx_r + 1'b1;
      end
    end else begin
      tick_cnt_r <= tick_cnt_r + 1'b1;
      if (sub_cnt_r == SUB_LAST) begin
        sub_cnt_r <= '0;
        phase_r   <= phase_r + 1'b1;
      end else begin
        sub_cnt_r <= sub_cnt_r + 1'b1;
      end
    end
  end

  // Pending/active frame buffers; a load on the transfer edge refills pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_r     <= '0;
      active_dp_r  <= '0;
      pending_r    <= '0;
      pending_dp_r <= '0;
      pend_flag_r  <= 1'b0;
    end else begin
      if (xfer_s) begin
        active_r    <= pending_r;
        active_dp_r <= pending_dp_r;
      end
      if (load) begin
        pending_r    <= value;
        pending_dp_r <= dp_in;
        pend_flag_r  <= 1'b1;
      end else if (xfer_s) begin
        pend_flag_r <= 1'b0;
      end
    end
  end

  hex2sseg u_hex2sseg (
    .hex (nibble_s),
    .seg (dec_seg_s)
  );

  // Leading-zero mask of the active frame and per-slot blank decision.
  always_comb begin
    val_ext_s                   = '0;
    val_ext_s[4*N_DIGITS-1:0]   = active_r;
    idx_ext_s                   = '0;
    idx_ext_s[IDX_W-1:0]        = idx_r;
    lz_full_s                   = lz_mask(val_ext_s, N_DIGITS);
    if (!en_mask[idx_r]) begin
      blank_s = 1'b1;
    end else if (lz_blank && lz_full_s[idx_ext_s]) begin
      blank_s = 1'b1;
    end else begin
      blank_s = 1'b0;
    end
  end

  // Next output values; segments stay valid for the whole slot while the anode is PWM-gated.
  always_comb begin
    an_next_s   = '1;
    sseg_next_s = SSEG_BLANK;
    dp_next_s   = 1'b1;
    if (blank_s) begin
      an_next_s   = '1;
      sseg_next_s = SSEG_BLANK;
      dp_next_s   = 1'b1;
    end else begin
      sseg_next_s = dec_seg_s;
      dp_next_s   = ~active_dp_r[idx_r];
      if (phase_r <= duty) begin
        an_next_s[idx_r] = 1'b0;
      end else begin
        an_next_s = '1;
      end
    end
  end

  // Output registers: anodes, segments and DP all update on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_r          <= '1;
      sseg_r        <= SSEG_BLANK;
      dp_r          <= 1'b1;
      load_ack_r    <= 1'b0;
      wrap_r        <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      an_r          <= an_next_s;
      sseg_r        <= sseg_next_s;
      dp_r          <= dp_next_s;
      load_ack_r    <= xfer_s;
      wrap_r        <= wrap_s;
      frame_start_r <= wrap_r;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl with DIV=8, 8 digits, 3 duty bits.
module tb_sseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  logic [31:0] value;
  logic [7:0]  dp_in;
  logic [7:0]  en_mask;
  logic        lz_blank;
  logic [2:0]  duty;
  logic        load_ack;
  logic        frame_start;
  logic [7:0]  an;
  logic [6:0]  sseg;
  logic        dp;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(
    .CLK_HZ     (8000),
    .REFRESH_HZ (1000),
    .N_DIGITS   (8),
    .DUTY_BITS  (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .value       (value),
    .dp_in       (dp_in),
    .en_mask     (en_mask),
    .lz_blank    (lz_blank),
    .duty        (duty),
    .load_ack    (load_ack),
    .frame_start (frame_start),
    .an          (an),
    .sseg        (sseg),
    .dp          (dp)
  );

  typedef struct {
    logic [31:0] value;
    logic [7:0]  dp_in;
    logic [7:0]  en_mask;
    logic        lz_blank;
    logic [2:0]  duty;
    int          exp_acks;
  } vec_t;

  typedef struct {
    logic [7:0] an;
    logic [6:0] sseg;
    logic       dp;
    logic       chk_dp;
    logic       fs;
  } exp_t;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   ack_total = 0;
  vec_t vecs [6];

  always @(negedge clk) begin
    if (reset_n === 1'b1 && load_ack === 1'b1) ack_total = ack_total + 1;
  end

  task automatic cmp(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s[%0d]: got %h, want %h", name, k, act, req);
    end
  endtask

  // Expected 64 samples of one frame, starting at the frame_start sample.
  function automatic void push_frame(input vec_t v);
    exp_t        e;
    int          s;
    int          p;
    logic [31:0] sh;
    logic        blank;
    for (int k = 0; k < 64; k++) begin
      s     = k / 8;
      p     = k % 8;
      sh    = v.value >> (4 * s);
      blank = !v.en_mask[s] || (v.lz_blank && s != 0 && sh == 32'h0);
      e.an  = 8'hFF;
      if (!blank && p <= int'(v.duty)) e.an[s] = 1'b0;
      e.sseg   = blank ? 7'h7F : SEG_TBL[sh[3:0]];
      e.dp     = ~v.dp_in[s];
      e.chk_dp = !blank;
      e.fs     = (k == 0);
      sb_q.push_back(e);
    end
  endfunction

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic check_frame(input string name);
    exp_t        e;
    bit          ok;
    logic [31:0] act;
    logic [31:0] req;
    wait_fs(ok);
    if (!ok) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_timeout: got no frame_start, want one within 200 cycles", name);
      sb_q.delete();
    end else begin
      for (int k = 0; k < 64 && sb_q.size() > 0; k++) begin
        if (k > 0) @(negedge clk);
        e   = sb_q.pop_front();
        act = {15'h0, an, sseg, frame_start, (e.chk_dp ? dp : 1'b1)};
        req = {15'h0, e.an, e.sseg, e.fs, (e.chk_dp ? e.dp : 1'b1)};
        cmp(name, k, act, req);
      end
    end
  endtask

  task automatic do_load(input vec_t v);
    value    = v.value;
    dp_in    = v.dp_in;
    en_mask  = v.en_mask;
    lz_blank = v.lz_blank;
    duty     = v.duty;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  initial begin
    vec_t vx;
    vec_t vy;
    vec_t vz;
    bit   ok;
    int   ack_base;

    vecs[0] = '{32'h0123_4567, 8'h00, 8'hFF, 1'b0, 3'd7, 1};
    vecs[1] = '{32'h0000_00A0, 8'h00, 8'hFF, 1'b1, 3'd7, 1};
    vecs[2] = '{32'h89AB_CDEF, 8'h81, 8'hFF, 1'b0, 3'd2, 1};
    vecs[3] = '{32'hFEDC_BA98, 8'h0F, 8'hA5, 1'b0, 3'd0, 1};
    vecs[4] = '{32'h0000_0000, 8'h01, 8'hFF, 1'b1, 3'd7, 1};
    vecs[5] = '{32'h0030_0000, 8'h20, 8'hFB, 1'b1, 3'd5, 1};

    reset_n  = 1'b0;
    load     = 1'b0;
    value    = 32'h0;
    dp_in    = 8'h00;
    en_mask  = 8'hFF;
    lz_blank = 1'b0;
    duty     = 3'd7;
    repeat (3) @(negedge clk);
    cmp("reset_state", 0, {21'h0, an, sseg, dp, load_ack, frame_start}, {21'h0, 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0});
    reset_n = 1'b1;
    @(negedge clk);
    cmp("first_update", 0, {16'h0, an, sseg, dp}, {16'h0, 8'hFE, 7'h40, 1'b1});

    // Table-driven frames: load mid-frame, check the next full frame and the ack count.
    foreach (vecs[i]) begin
      @(negedge clk);
      ack_base = ack_total;
      push_frame(vecs[i]);
      do_load(vecs[i]);
      check_frame($sformatf("vec%0d", i));
      cmp($sformatf("vec%0d_acks", i), 0, 32'(ack_total - ack_base), 32'(vecs[i].exp_acks));
    end

    // Two loads in one frame: only the second is shown, with a single ack.
    vx = '{32'h1111_2222, 8'h10, 8'hFF, 1'b0, 3'd7, 1};
    vy = '{32'hC0DE_5A7E, 8'h02, 8'hFF, 1'b0, 3'd7, 1};
    wait_fs(ok);
    cmp("dbl_sync", 0, {31'h0, ok}, 32'h1);
    ack_base = ack_total;
    do_load(vx);
    repeat (10) @(negedge clk);
    do_load(vy);
    push_frame(vy);
    check_frame("dbl_load");
    cmp("dbl_acks", 0, 32'(ack_total - ack_base), 32'd1);

    // Load on the transfer edge: old pending shows first, new data the frame after.
    vx = '{32'h7654_3210, 8'h00, 8'hFF, 1'b0, 3'd7, 2};
    vy = '{32'hABCD_EF01, 8'hF0, 8'hFF, 1'b0, 3'd7, 2};
    wait_fs(ok);
    cmp("coin_sync", 0, {31'h0, ok}, 32'h1);
    ack_base = ack_total;
    do_load(vx);
    repeat (61) @(negedge clk);
    do_load(vy);
    push_frame(vx);
    check_frame("coin_old");
    push_frame(vy);
    check_frame("coin_new");
    cmp("coin_acks", 0, 32'(ack_total - ack_base), 32'd2);

    // Async reset at tick_cnt=3 with a pending frame, which must be discarded.
    vz = '{32'h1357_9BDF, 8'hFF, 8'hFF, 1'b0, 3'd7, 0};
    wait_fs(ok);
    cmp("rst_sync", 0, {31'h0, ok}, 32'h1);
    do_load(vz);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    cmp("async_rst", 0, {21'h0, an, sseg, dp, load_ack, frame_start}, {21'h0, 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0});
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    ack_base = ack_total;
    vz = '{32'h0000_0000, 8'h00, 8'hFF, 1'b0, 3'd7, 0};
    push_frame(vz);
    check_frame("post_rst");
    cmp("post_rst_acks", 0, 32'(ack_total - ack_base), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
